// File: rtl/rip_axi_slave_memory_if.sv
// AXI4 bundle shared by the memory responder and its requesters.
// Carries only the channel signals the memory model uses.
interface rip_axi_interface #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/rip_axi_slave_memory.sv
// Single-outstanding AXI4 responder backed by a word-organised byte-lane memory.
// One transaction at a time; reads take one cycle of registered memory
// access per beat before rvalid is raised.
module rip_axi_slave_memory #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input logic             clk,
  input logic             rstn,
  rip_axi_interface.slave S_AXI
);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

  state_t                  state_q, state_d;
  logic                    prio_wr_q, prio_wr_d;   // 1: write wins a simultaneous request
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_q, beat_d;
  logic [1:0]              burst_q, burst_d;
  logic                    decerr_q, decerr_d;
  logic                    slverr_q, slverr_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic                    grant_w, grant_r;
  logic                    wready;
  logic                    mem_we;
  logic                    rd_load;
  logic                    in_range;
  logic                    beat_last;
  logic [IDX_W-1:0]        word_idx;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    unused_ok;

  // Transfer size is always treated as a full word; low address bits are dropped.
  assign unused_ok = ^{S_AXI.awsize, S_AXI.arsize, S_AXI.awaddr[1:0], S_AXI.araddr[1:0]};

  // Out-of-range beats never touch the array, so the index is never aliased.
  assign in_range  = (addr_q < ADDR_WIDTH'(MEM_BYTES));
  assign word_idx  = addr_q[IDX_W+1:2];
  assign beat_last = (beat_q == len_q);
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_WIDTH'(4);
  assign wready    = (state_q == W_DATA) && rstn;

  assign S_AXI.awready = grant_w;
  assign S_AXI.arready = grant_r;
  assign S_AXI.wready  = wready;
  assign S_AXI.bvalid  = (state_q == W_RESP);
  assign S_AXI.bid     = id_q;
  assign S_AXI.bresp   = bresp_q;
  assign S_AXI.rvalid  = rvalid_q;
  assign S_AXI.rid     = id_q;
  assign S_AXI.rdata   = rdata_q;
  assign S_AXI.rresp   = rresp_q;
  assign S_AXI.rlast   = rlast_q;

  // Next-state: arbitration, burst sequencing and response formation.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    decerr_d  = decerr_q;
    slverr_d  = slverr_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    grant_w   = 1'b0;
    grant_r   = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_w = rstn && S_AXI.awvalid && (!S_AXI.arvalid || prio_wr_q);
        grant_r = rstn && S_AXI.arvalid && (!S_AXI.awvalid || !prio_wr_q);
        if (grant_w) begin
          id_d      = S_AXI.awid;
          addr_d    = {S_AXI.awaddr[ADDR_WIDTH-1:2], 2'b00};
          len_d     = S_AXI.awlen;
          burst_d   = S_AXI.awburst;
          beat_d    = 8'd0;
          decerr_d  = 1'b0;
          slverr_d  = 1'b0;
          prio_wr_d = 1'b0;
          state_d   = W_DATA;
        end else if (grant_r) begin
          id_d      = S_AXI.arid;
          addr_d    = {S_AXI.araddr[ADDR_WIDTH-1:2], 2'b00};
          len_d     = S_AXI.arlen;
          burst_d   = S_AXI.arburst;
          beat_d    = 8'd0;
          rvalid_d  = 1'b0;
          prio_wr_d = 1'b1;
          state_d   = R_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI.wvalid) begin
          mem_we   = in_range;
          decerr_d = decerr_q | !in_range;
          slverr_d = slverr_q | (S_AXI.wlast != beat_last);
          addr_d   = addr_next;
          beat_d   = beat_q + 8'd1;
          if (beat_last) begin
            bresp_d = decerr_d ? 2'b11 : (slverr_d ? 2'b10 : 2'b00);
            state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (S_AXI.bready) state_d = IDLE;
      end
      R_DATA: begin
        if (!rvalid_q) begin
          rd_load  = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = beat_last;
          rresp_d  = in_range ? 2'b00 : 2'b11;
        end else if (S_AXI.rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            addr_d = addr_next;
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      decerr_q  <= 1'b0;
      slverr_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      decerr_q  <= decerr_d;
      slverr_q  <= slverr_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && wready) begin
      for (int i = 0; i < 4; i++) begin
        if (S_AXI.wstrb[i]) mem[word_idx][i*8 +: 8] <= S_AXI.wdata[i*8 +: 8];
      end
    end
  end

  // Registered read port; out-of-range beats return zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (rd_load) begin
      rdata_q <= in_range ? mem[word_idx] : '0;
    end
  end
endmodule

// File: doc/rip_axi_slave_memory.md
RIP_AXI_SLAVE_MEMORY -- requirements
Module: rip_axi_slave_memory

Interface
REQ-001 Parameter ID_WIDTH, default 4: AXI ID width.
REQ-002 Parameter ADDR_WIDTH, default 32: AXI address width.
REQ-003 Parameter DATA_WIDTH, default 32: AXI data width, fixed at 32 bits (4 byte lanes).
REQ-004 Parameter MEM_BYTES, default 4096: backing store size in bytes, power of two, multiple of 4.
REQ-005 Port clk, input, 1 bit: clock; all logic SHALL be on the rising edge.
REQ-006 Port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port S_AXI, rip_axi_interface.slave modport: AXI4 responder side. Used signals:
- AW channel: awid, awaddr, awlen, awsize, awburst, awvalid, awready.
- W channel: wdata, wstrb, wlast, wvalid, wready.
- B channel: bid, bresp, bvalid, bready.
- AR channel: arid, araddr, arlen, arsize, arburst, arvalid, arready.
- R channel: rid, rdata, rresp, rlast, rvalid, rready.
- All other interface signals SHALL be ignored.

Function
REQ-008 The block SHALL contain a byte-addressable memory of MEM_BYTES bytes, organised as MEM_BYTES/4 32-bit words with per-byte write enables.
REQ-009 The FSM SHALL have exactly four states: IDLE, W_DATA, W_RESP, R_DATA. At most one transaction SHALL be active at a time.
REQ-010 In IDLE, awready and arready SHALL be decoded combinationally from state and the valid inputs. At most one of them SHALL be 1 in any cycle.
REQ-011 IDLE arbitration:
- Only awvalid: grant write.
- Only arvalid: grant read.
- Both: grant the type not granted last; after reset, write wins.
REQ-012 On an AW handshake, the block SHALL latch awid, the word address (awaddr with bits [1:0] cleared), awlen and awburst; clear the beat counter; and enter W_DATA.
REQ-013 In W_DATA, wready SHALL be 1. On each W handshake, the byte lanes selected by wstrb SHALL be written at the current word address.
REQ-014 Address update: INCR (2'b01) and WRAP (2'b10) SHALL add 4 per beat; FIXED (2'b00) SHALL keep the address constant. The address SHALL NOT wrap modulo MEM_BYTES.
REQ-015 The burst SHALL end on beat awlen+1 regardless of wlast; the FSM then enters W_RESP.
REQ-016 In W_RESP, bvalid SHALL be 1 and bid SHALL equal the latched awid. bvalid SHALL hold until bready; on the B handshake the FSM returns to IDLE.
REQ-017 bresp encoding:
- DECERR (2'b11) if any beat address was >= MEM_BYTES; that beat's write SHALL be dropped.
- Otherwise SLVERR (2'b10) if wlast was 1 on a beat other than the last, or 0 on the last beat.
- Otherwise OKAY (2'b00).
REQ-018 On an AR handshake, the block SHALL latch arid, the word address, arlen and arburst, and enter R_DATA.
REQ-019 In R_DATA, the first rvalid SHALL assert two cycles after the AR handshake, allowing one cycle for the registered memory read.
REQ-020 After each R handshake, the next beat's rvalid SHALL assert two cycles later. rvalid, rdata, rresp, rid and rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-021 R beat fields:
- rid SHALL equal the latched arid.
- rlast SHALL be 1 only on beat arlen+1.
- An out-of-range beat SHALL return rdata=0 and rresp=DECERR; other beats SHALL return rresp=OKAY.
- After the rlast handshake, the FSM SHALL return to IDLE.
REQ-022 awsize and arsize other than 3'b010 SHALL be treated as 3'b010.
REQ-023 No memory write SHALL occur outside W_DATA W handshakes.

Reset
REQ-024 While rstn=0, at the clock edge:
- FSM SHALL go to IDLE.
- Arbitration priority SHALL reset to write.
- bvalid, rvalid and rlast SHALL be 0; bresp, rresp, bid, rid and rdata SHALL be 0.
- awready, wready and arready SHALL be 0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 Reset mid-burst SHALL abandon the transaction with no B or R response. Beats already written SHALL remain in memory.

Verification
REQ-027 Single write: AW addr 0x10, len 0, data 0xDEADBEEF, wstrb 4'b1111 -> bresp 2'b00. Then AR addr 0x10 -> rdata 0xDEADBEEF, rlast=1, rresp 2'b00, first rvalid two cycles after the AR handshake.
REQ-028 Byte strobe: after 0xDEADBEEF is written at 0x10, write 0x00000055 with wstrb 4'b0001 -> read 0x10 returns 0xDEADBE55.
REQ-029 INCR burst: AW 0x100, len 3, data 1,2,3,4 with bready held 0 for 5 cycles -> bvalid held stable, bid equals awid. Then AR 0x100, len 3, INCR with rready toggling -> data 1,2,3,4, rlast only on beat 4.
REQ-030 Arbitration and errors:
- awvalid and arvalid asserted in the same cycle, twice -> write granted first, read second.
- AW 0xFFC with len 1 (MEM_BYTES=4096) -> bresp 2'b11; word 0xFFC written; no aliasing to word 0.
- wlast=1 on beat 1 of a len-3 burst -> bresp 2'b10.
REQ-031 Reset mid-burst: rstn=0 after 2 of 4 W beats -> no bvalid; next AR to the same base returns beats 1-2 written and beats 3-4 at their prior values.
